// File: rtl/bonus_supply_pkg.sv
// Shared defaults and types for the bonus spawner and its per-slot engines.
// Pure declarations; no timing or flow-control behaviour of its own.
package bonus_supply_pkg;

  localparam int BONUS_SLOT_NUM     = 4;
  localparam int BONUS_SLOT_IDX_W   = 2;
  localparam int BONUS_TYPE_NUM     = 3;
  localparam int BONUS_TYPE_W       = 2;
  localparam int BONUS_X_SIZE       = 32;
  localparam int BONUS_Y_SIZE       = 32;
  localparam int BONUS_SPAWN_PERIOD = 300;
  localparam int BONUS_LIFE_FRAMES  = 600;
  localparam int BONUS_BLINK_FRAMES = 120;
  localparam int BONUS_SPEED        = 1;
  localparam int BONUS_Y_LIMIT      = 480;
  localparam int BONUS_X_OFFSET     = 32;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_ACTIVE = 2'd1,
    SLOT_BLINK  = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pix_t;

endpackage

// File: rtl/bonus_slot.sv
// One falling bonus: IDLE/ACTIVE/BLINK FSM, position, lifetime and pixel hit test.
// State updates one cycle after tick/spawn/kill; hit test is combinational; no backpressure.
module bonus_slot
  import bonus_supply_pkg::*;
#(
  parameter int X_SIZE       = BONUS_X_SIZE,
  parameter int Y_SIZE       = BONUS_Y_SIZE,
  parameter int LIFE_FRAMES  = BONUS_LIFE_FRAMES,
  parameter int BLINK_FRAMES = BONUS_BLINK_FRAMES,
  parameter int SPEED        = BONUS_SPEED,
  parameter int Y_LIMIT      = BONUS_Y_LIMIT,
  parameter int TYPE_W       = BONUS_TYPE_W
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              spawn_i,
  input  logic [9:0]        spawn_x_i,
  input  logic [TYPE_W-1:0] spawn_type_i,
  input  logic              kill_i,
  input  logic              blink_phase_i,
  input  pix_t              req_i,
  output logic              busy_o,
  output logic              hit_o,
  output logic [TYPE_W-1:0] type_o,
  output logic [9:0]        addr_o
);

  localparam int LIFE_W = $clog2(LIFE_FRAMES + 1);

  slot_state_e       state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [LIFE_W-1:0] life_q, life_d, life_next;
  logic [TYPE_W-1:0] type_q, type_d;
  logic [10:0]       y_next;
  logic [9:0]        col, row;
  logic              visible;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    life_d    = life_q;
    type_d    = type_q;
    y_next    = {1'b0, y_q} + 11'(SPEED);
    life_next = (life_q == '0) ? '0 : life_q - LIFE_W'(1);
    case (state_q)
      SLOT_IDLE: begin
        if (spawn_i) begin
          state_d = SLOT_ACTIVE;
          x_d     = spawn_x_i;
          y_d     = '0;
          life_d  = LIFE_W'(LIFE_FRAMES);
          type_d  = spawn_type_i;
        end
      end
      default: begin
        // A collection beats a same-cycle frame move.
        if (kill_i) begin
          state_d = SLOT_IDLE;
        end else if (tick_i) begin
          y_d    = y_next[9:0];
          life_d = life_next;
          if (life_next == '0 || y_next >= 11'(Y_LIMIT)) begin
            state_d = SLOT_IDLE;
          end else if (state_q == SLOT_ACTIVE && life_next <= LIFE_W'(BLINK_FRAMES)) begin
            state_d = SLOT_BLINK;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      life_q  <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      life_q  <= life_d;
      type_q  <= type_d;
    end
  end

  always_comb begin
    col     = req_i.x - x_q;
    row     = req_i.y - y_q;
    visible = (state_q == SLOT_ACTIVE) || (state_q == SLOT_BLINK && !blink_phase_i);
    hit_o   = visible && (req_i.x >= x_q) && (col < 10'(X_SIZE))
                      && (req_i.y >= y_q) && (row < 10'(Y_SIZE));
    addr_o  = hit_o ? (row * 10'(X_SIZE) + col) : '0;
  end

  assign busy_o = (state_q != SLOT_IDLE);
  assign type_o = type_q;

endmodule

// File: rtl/bonus_supply.sv
// Bonus spawner: frame-tick spawn arbiter over SLOT_NUM slots plus lowest-index hit mux.
// Hit/collect/drop outputs registered (1 cycle); no backpressure, events are single-cycle pulses.
module bonus_supply
  import bonus_supply_pkg::*;
#(
  parameter int SLOT_NUM     = BONUS_SLOT_NUM,
  parameter int SLOT_IDX_W   = BONUS_SLOT_IDX_W,
  parameter int TYPE_NUM     = BONUS_TYPE_NUM,
  parameter int TYPE_W       = BONUS_TYPE_W,
  parameter int X_SIZE       = BONUS_X_SIZE,
  parameter int Y_SIZE       = BONUS_Y_SIZE,
  parameter int SPAWN_PERIOD = BONUS_SPAWN_PERIOD,
  parameter int LIFE_FRAMES  = BONUS_LIFE_FRAMES,
  parameter int BLINK_FRAMES = BONUS_BLINK_FRAMES,
  parameter int SPEED        = BONUS_SPEED,
  parameter int Y_LIMIT      = BONUS_Y_LIMIT
) (
  input  logic                  clk_vga,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  v_sync_i,
  input  logic [15:0]           rand_i,
  input  logic [9:0]            req_x_addr_i,
  input  logic [9:0]            req_y_addr_i,
  input  logic                  crash_i,
  output logic                  hit_vali_o,
  output logic [SLOT_IDX_W-1:0] hit_idx_o,
  output logic [TYPE_W-1:0]     hit_type_o,
  output logic [9:0]            sprite_addr_o,
  output logic                  collect_o,
  output logic [TYPE_W-1:0]     collect_type_o,
  output logic                  spawn_drop_o,
  output logic [SLOT_IDX_W:0]   active_cnt_o
);

  localparam int SPAWN_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  logic                  v_sync_q, v_sync_d;
  logic [3:0]            frame_cnt_q, frame_cnt_d;
  logic [SPAWN_W-1:0]    spawn_cnt_q, spawn_cnt_d;
  logic                  hit_vld_q, hit_vld_d;
  logic [SLOT_IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic [TYPE_W-1:0]     hit_type_q, hit_type_d;
  logic [9:0]            sprite_addr_q, sprite_addr_d;
  logic                  collect_q, collect_d;
  logic [TYPE_W-1:0]     collect_type_q, collect_type_d;
  logic                  spawn_drop_q, spawn_drop_d;

  logic                  frame_tick, spawn_wrap, free_seen, collect_fire;
  logic [9:0]            spawn_x;
  logic [TYPE_W-1:0]     spawn_type;
  logic [SLOT_NUM-1:0]   slot_busy, slot_hit, spawn_vec, kill_vec;
  logic [TYPE_W-1:0]     slot_type [SLOT_NUM];
  logic [9:0]            slot_addr [SLOT_NUM];
  pix_t                  req;
  logic                  unused_rand;

  assign unused_rand = ^rand_i[13:9];
  assign req         = '{x: req_x_addr_i, y: req_y_addr_i};
  assign frame_tick  = v_sync_i && !v_sync_q && en_i;
  assign spawn_wrap  = frame_tick && (spawn_cnt_q == SPAWN_W'(SPAWN_PERIOD - 1));
  assign spawn_x     = 10'(rand_i[8:0]) + 10'(BONUS_X_OFFSET);
  assign spawn_type  = (32'(rand_i[15:14]) >= TYPE_NUM) ? '0 : TYPE_W'(rand_i[15:14]);

  // Only currently IDLE slots are candidates, so a slot being freed this cycle is never picked.
  always_comb begin
    free_seen = 1'b0;
    spawn_vec = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (!slot_busy[i] && !free_seen) spawn_vec[i] = spawn_wrap;
      free_seen = free_seen | !slot_busy[i];
    end
  end

  always_comb begin
    collect_fire = crash_i && hit_vld_q && slot_busy[hit_idx_q];
    kill_vec     = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      kill_vec[i] = collect_fire && (hit_idx_q == SLOT_IDX_W'(i));
    end
  end

  for (genvar g = 0; g < SLOT_NUM; g++) begin : g_slot
    bonus_slot #(
      .X_SIZE      (X_SIZE),
      .Y_SIZE      (Y_SIZE),
      .LIFE_FRAMES (LIFE_FRAMES),
      .BLINK_FRAMES(BLINK_FRAMES),
      .SPEED       (SPEED),
      .Y_LIMIT     (Y_LIMIT),
      .TYPE_W      (TYPE_W)
    ) u_slot (
      .clk_vga      (clk_vga),
      .rst_n        (rst_n),
      .tick_i       (frame_tick),
      .spawn_i      (spawn_vec[g]),
      .spawn_x_i    (spawn_x),
      .spawn_type_i (spawn_type),
      .kill_i       (kill_vec[g]),
      .blink_phase_i(frame_cnt_q[3]),
      .req_i        (req),
      .busy_o       (slot_busy[g]),
      .hit_o        (slot_hit[g]),
      .type_o       (slot_type[g]),
      .addr_o       (slot_addr[g])
    );
  end

  always_comb begin
    v_sync_d       = v_sync_i;
    frame_cnt_d    = frame_tick ? frame_cnt_q + 4'd1 : frame_cnt_q;
    spawn_cnt_d    = spawn_cnt_q;
    if (frame_tick) spawn_cnt_d = spawn_wrap ? '0 : spawn_cnt_q + SPAWN_W'(1);
    spawn_drop_d   = spawn_wrap && !free_seen;
    collect_d      = collect_fire;
    collect_type_d = collect_fire ? hit_type_q : '0;
    hit_vld_d      = 1'b0;
    hit_idx_d      = '0;
    hit_type_d     = '0;
    sprite_addr_d  = '0;
    // Scan downwards so the lowest-index visible slot is the one left standing.
    for (int i = SLOT_NUM - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit_vld_d     = 1'b1;
        hit_idx_d     = SLOT_IDX_W'(i);
        hit_type_d    = slot_type[i];
        sprite_addr_d = slot_addr[i];
      end
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      v_sync_q       <= 1'b0;
      frame_cnt_q    <= '0;
      spawn_cnt_q    <= '0;
      hit_vld_q      <= 1'b0;
      hit_idx_q      <= '0;
      hit_type_q     <= '0;
      sprite_addr_q  <= '0;
      collect_q      <= 1'b0;
      collect_type_q <= '0;
      spawn_drop_q   <= 1'b0;
    end else begin
      v_sync_q       <= v_sync_d;
      frame_cnt_q    <= frame_cnt_d;
      spawn_cnt_q    <= spawn_cnt_d;
      hit_vld_q      <= hit_vld_d;
      hit_idx_q      <= hit_idx_d;
      hit_type_q     <= hit_type_d;
      sprite_addr_q  <= sprite_addr_d;
      collect_q      <= collect_d;
      collect_type_q <= collect_type_d;
      spawn_drop_q   <= spawn_drop_d;
    end
  end

  always_comb begin
    active_cnt_o = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      active_cnt_o = active_cnt_o + (SLOT_IDX_W + 1)'(slot_busy[i]);
    end
  end

  assign hit_vali_o     = hit_vld_q;
  assign hit_idx_o      = hit_idx_q;
  assign hit_type_o     = hit_type_q;
  assign sprite_addr_o  = sprite_addr_q;
  assign collect_o      = collect_q;
  assign collect_type_o = collect_type_q;
  assign spawn_drop_o   = spawn_drop_q;

endmodule

// File: tb/tb_bonus_supply.sv
// Directed bench for bonus_supply with shortened spawn/life periods (30 / 150 / blink 30).
// Frame counter T counts only enabled ticks; slot y equals T minus its spawn tick.
module tb_bonus_supply;

  logic        clk_vga = 1'b0;
  logic        rst_n, en_i, v_sync_i, crash_i;
  logic [15:0] rand_i;
  logic [9:0]  req_x, req_y;
  logic        hit_vali;
  logic [1:0]  hit_idx, hit_type, collect_type;
  logic [9:0]  sprite_addr;
  logic        collect, spawn_drop;
  logic [2:0]  active_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int t_cnt    = 0;

  bonus_supply #(
    .SPAWN_PERIOD(30),
    .LIFE_FRAMES (150),
    .BLINK_FRAMES(30)
  ) dut (
    .clk_vga       (clk_vga),
    .rst_n         (rst_n),
    .en_i          (en_i),
    .v_sync_i      (v_sync_i),
    .rand_i        (rand_i),
    .req_x_addr_i  (req_x),
    .req_y_addr_i  (req_y),
    .crash_i       (crash_i),
    .hit_vali_o    (hit_vali),
    .hit_idx_o     (hit_idx),
    .hit_type_o    (hit_type),
    .sprite_addr_o (sprite_addr),
    .collect_o     (collect),
    .collect_type_o(collect_type),
    .spawn_drop_o  (spawn_drop),
    .active_cnt_o  (active_cnt)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame_tick();
    v_sync_i = 1'b0;
    @(posedge clk_vga); #1;
    v_sync_i = 1'b1;
    @(posedge clk_vga); #1;
    v_sync_i = 1'b0;
    if (en_i) t_cnt++;
  endtask

  task automatic ticks_to(input int t);
    while (t_cnt < t) frame_tick();
  endtask

  task automatic probe(input int x, input int y, input logic vld, input int idx,
                       input int typ, input int addr, input string tag);
    req_x = 10'(x);
    req_y = 10'(y);
    @(posedge clk_vga); #1;
    check_val({tag, ".vld"},  32'(hit_vali),    32'(vld));
    check_val({tag, ".idx"},  32'(hit_idx),     idx);
    check_val({tag, ".type"}, 32'(hit_type),    typ);
    check_val({tag, ".addr"}, 32'(sprite_addr), addr);
  endtask

  initial begin
    rst_n = 1'b0; en_i = 1'b0; v_sync_i = 1'b0; crash_i = 1'b0;
    rand_i = 16'h0000; req_x = '0; req_y = '0;
    #12;
    check_val("rst_active", 32'(active_cnt), 0);
    check_val("rst_hit",    32'(hit_vali),   0);
    check_val("rst_collect", 32'(collect),   0);
    check_val("rst_drop",   32'(spawn_drop), 0);
    @(negedge clk_vga);
    rst_n = 1'b1; en_i = 1'b1; rand_i = 16'h4010;
    @(posedge clk_vga); #1;

    ticks_to(29);
    check_val("pre_spawn_cnt", 32'(active_cnt), 0);
    ticks_to(30);
    check_val("first_spawn_cnt", 32'(active_cnt), 1);
    check_val("first_spawn_drop", 32'(spawn_drop), 0);
    probe(48, 0,  1'b1, 0, 1, 0,    "x_origin");
    probe(47, 0,  1'b0, 0, 0, 0,    "x_left");
    probe(79, 31, 1'b1, 0, 1, 1023, "corner");
    probe(80, 0,  1'b0, 0, 0, 0,    "x_right");
    probe(48, 32, 1'b0, 0, 0, 0,    "y_below");

    en_i = 1'b0;
    repeat (5) frame_tick();
    check_val("frozen_cnt", 32'(active_cnt), 1);
    probe(48, 0, 1'b1, 0, 1, 0, "frozen_pos");
    probe(0, 0, 1'b0, 0, 0, 0, "no_hit");
    crash_i = 1'b1;
    @(posedge clk_vga); #1;
    crash_i = 1'b0;
    check_val("crash_no_hit_collect", 32'(collect), 0);
    check_val("crash_no_hit_cnt", 32'(active_cnt), 1);
    en_i = 1'b1;

    rand_i = 16'h8100; ticks_to(60);
    rand_i = 16'hC180; ticks_to(90);
    rand_i = 16'h4040; ticks_to(120);
    check_val("fill_cnt", 32'(active_cnt), 4);
    ticks_to(130);
    probe(53, 110, 1'b1, 0, 1, 325, "hit_y100");
    crash_i = 1'b1;
    @(posedge clk_vga); #1;
    crash_i = 1'b0;
    check_val("collect_pulse", 32'(collect), 1);
    check_val("collect_type", 32'(collect_type), 1);
    check_val("collect_cnt", 32'(active_cnt), 3);
    @(posedge clk_vga); #1;
    check_val("collect_end", 32'(collect), 0);
    probe(416, 40, 1'b1, 2, 0, 0,  "type_map");
    probe(290, 71, 1'b1, 1, 2, 34, "slot1");

    rand_i = 16'h0000; ticks_to(150);
    check_val("refill_cnt", 32'(active_cnt), 4);
    ticks_to(180);
    check_val("drop_pulse", 32'(spawn_drop), 1);
    check_val("drop_cnt", 32'(active_cnt), 4);
    @(posedge clk_vga); #1;
    check_val("drop_end", 32'(spawn_drop), 0);

    ticks_to(209);
    probe(32, 59, 1'b1, 0, 0, 0, "pre_coinc");
    crash_i = 1'b1; v_sync_i = 1'b1;
    @(posedge clk_vga); #1;
    crash_i = 1'b0; v_sync_i = 1'b0; t_cnt++;
    check_val("coinc_collect", 32'(collect), 1);
    check_val("coinc_ctype", 32'(collect_type), 0);
    check_val("coinc_drop", 32'(spawn_drop), 1);
    check_val("coinc_cnt", 32'(active_cnt), 2);

    rand_i = 16'h81F0;
    ticks_to(239);
    probe(96, 119, 1'b1, 3, 1, 0, "pre_blink");
    ticks_to(240);
    check_val("reuse_cnt", 32'(active_cnt), 2);
    probe(528, 0, 1'b1, 0, 2, 0, "reuse_slot0");
    ticks_to(248);
    probe(96, 128, 1'b0, 0, 0, 0, "blink_off");
    ticks_to(256);
    probe(96, 136, 1'b1, 3, 1, 0, "blink_on");
    ticks_to(264);
    probe(96, 144, 1'b0, 0, 0, 0, "blink_off2");
    ticks_to(270);
    check_val("expire_cnt", 32'(active_cnt), 2);
    probe(96, 150, 1'b0, 0, 0, 0, "expired");
    probe(528, 0, 1'b1, 1, 2, 0, "skip_dying");

    #3;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_hit", 32'(hit_vali), 0);
    check_val("async_rst_cnt", 32'(active_cnt), 0);
    check_val("async_rst_type", 32'(hit_type), 0);
    @(posedge clk_vga); #1;
    rst_n = 1'b1;
    @(posedge clk_vga); #1;
    check_val("post_rst_cnt", 32'(active_cnt), 0);
    check_val("post_rst_collect", 32'(collect), 0);
    check_val("post_rst_hit", 32'(hit_vali), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
